stopwatch_core: RTL and testbench
=================================

STOPWATCH_CORE -- requirements
Module: stopwatch_core

Interface
REQ-001 SHALL have parameter MIN_MAX, default 59, meaning the highest minutes value before wrap (BCD-encodable, 1..99).
REQ-002 SHALL have port CLOCK  input  1  system clock (50 MHz); all state changes on negedge CLOCK, matching the 100 Hz divider that feeds this block.
REQ-003 SHALL have port RESET_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port _100Hz_clk  input  1  100 Hz square wave from the divider, already in the CLOCK domain.
REQ-005 SHALL have port start_stop  input  1  one-CLOCK debounced key pulse.
REQ-006 SHALL have port lap  input  1  one-CLOCK debounced key pulse.
REQ-007 SHALL have port clear  input  1  one-CLOCK debounced key pulse.
REQ-008 SHALL have port disp_bcd  output  24  display digits {min_t,min_u,sec_t,sec_u,cs_t,cs_u}, 4 bits each.
REQ-009 SHALL have port running  output  1  high in RUN and LAP.
REQ-010 SHALL have port overflow  output  1  one-CLOCK pulse on wrap from MIN_MAX:59.99 to 00:00.00.

Function
REQ-011 SHALL detect a tick when the registered previous sample of _100Hz_clk is 0 and the current sample is 1; exactly one tick per rising edge.
REQ-012 SHALL implement FSM states IDLE, RUN, LAP, PAUSE.
REQ-013 Transitions SHALL be: IDLE-start_stop->RUN; RUN-start_stop->PAUSE; RUN-lap->LAP; LAP-lap->RUN; LAP-start_stop->PAUSE; PAUSE-start_stop->RUN; PAUSE-lap->IDLE with count zeroed; any state-clear->IDLE with count zeroed.
REQ-014 Key priority in one cycle SHALL be clear > start_stop > lap; lower-priority keys in that cycle are ignored.
REQ-015 The live count SHALL advance by 1 cs on a tick only if the current (pre-transition) state is RUN or LAP; the updated count is visible one CLOCK after the tick cycle.
REQ-016 Count digits SHALL be BCD: cs 00..99, sec 00..59, min 00..MIN_MAX; each carry ripples in the same cycle.
REQ-017 At MIN_MAX:59.99 a tick SHALL wrap all digits to 00:00.00, assert overflow for one CLOCK, and keep the state unchanged.
REQ-018 On entry to LAP the live count (post-increment if a tick coincides) SHALL be copied to a lap register; disp_bcd shows the lap register in LAP and the live count in all other states.
REQ-019 A clear coinciding with a tick SHALL yield 00:00.00 with no overflow pulse.
REQ-020 Ticks in IDLE or PAUSE SHALL leave the count unchanged.

Reset
REQ-021 RESET_n low SHALL immediately force state IDLE, live and lap registers 0, disp_bcd 24'h000000, running 0, overflow 0, previous-sample register 0.
REQ-022 Reset deassertion mid-period SHALL NOT produce a tick unless a genuine 0->1 edge on _100Hz_clk is subsequently sampled.

Structure
REQ-023 State encodings and the BCD digit-width constant SHALL live in shared package watch_pkg.
REQ-024 One sub-module, bcd_digit (counter with parameterised modulus, enable, clear, carry out), SHALL be instantiated per digit.

Verification
REQ-025 Reset, start_stop, then 100 ticks -> disp_bcd = 00:01.00, running = 1.
REQ-026 Preload 00:59.99 in RUN, one tick -> 01:00.00 one CLOCK later, no overflow.
REQ-027 Run to 59:59.99, one tick -> 00:00.00, overflow high for exactly one CLOCK, state RUN.
REQ-028 At 00:12.34 pulse lap, then 50 ticks -> disp_bcd holds 00:12.34; pulse lap again -> 00:12.84.
REQ-029 clear and start_stop in same cycle while in RUN at 00:05.00 -> IDLE, 00:00.00, running 0.
REQ-030 Assert RESET_n low mid-count at 03:21.07 -> all outputs 0 asynchronously; after release, no count change until start_stop plus a rising edge on _100Hz_clk.

Source files
------------

// File: rtl/watch_pkg.sv
// Shared definitions for the stopwatch slice.
//   state_t   : stopwatch control states
//   DIGIT_W   : width of one BCD display digit
//   NUM_DIGITS: digits in the count {min_t,min_u,sec_t,sec_u,cs_t,cs_u}
//   to_bcd2   : two-digit BCD encoding of a small constant (0..99)
package watch_pkg;

    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned NUM_DIGITS = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        LAP   = 2'd2,
        PAUSE = 2'd3
    } state_t;

    function automatic logic [2*DIGIT_W-1:0] to_bcd2(input int unsigned v);
        to_bcd2 = {DIGIT_W'(v / 10), DIGIT_W'(v % 10)};
    endfunction

endpackage

// File: rtl/stopwatch_core_if.sv
// Key and display bundle of the stopwatch.
//   _100Hz_clk, start_stop, lap, clear : divider output and debounced keys
//   disp_bcd, running, overflow        : display digits and status
// master drives keys/divider, slave is the stopwatch side.
interface stopwatch_core_if;
    import watch_pkg::*;

    logic                            _100Hz_clk;
    logic                            start_stop;
    logic                            lap;
    logic                            clear;
    logic [NUM_DIGITS*DIGIT_W-1:0]   disp_bcd;
    logic                            running;
    logic                            overflow;

    modport master (
        output _100Hz_clk, start_stop, lap, clear,
        input  disp_bcd, running, overflow
    );

    modport slave (
        input  _100Hz_clk, start_stop, lap, clear,
        output disp_bcd, running, overflow
    );

endinterface

// File: rtl/stopwatch_core_bcd_digit.sv
// One BCD digit counter, updated on the falling clock edge.
//   clk, rst_n : clock (negedge active), async active-low reset
//   en         : advance by one this cycle
//   clr        : synchronous zero, overrides en
//   q          : current digit
//   q_next     : value q takes at the next edge (used for lap capture)
//   carry      : en while q is at MODULUS-1 (digit rolls to 0)
module bcd_digit
    import watch_pkg::*;
#(
    parameter int unsigned MODULUS = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               clr,
    output logic [DIGIT_W-1:0] q,
    output logic [DIGIT_W-1:0] q_next,
    output logic               carry
);

    localparam logic [DIGIT_W-1:0] LAST = DIGIT_W'(MODULUS - 1);

    always_comb begin
        carry = en && (q == LAST);
        if (clr) begin
            q_next = '0;
        end else if (carry) begin
            q_next = '0;
        end else if (en) begin
            q_next = q + DIGIT_W'(1);
        end else begin
            q_next = q;
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch core: BCD mm:ss.cc counter with run/lap/pause control.
//   CLOCK       : system clock, all state changes on its falling edge
//   RESET_n     : async active-low reset
//   _100Hz_clk  : 100 Hz square wave; each rising edge is one centisecond
//   start_stop, lap, clear : one-cycle key pulses (clear > start_stop > lap)
//   disp_bcd    : {min_t,min_u,sec_t,sec_u,cs_t,cs_u}; lap register in LAP
//   running     : high in RUN and LAP
//   overflow    : one-cycle pulse when MIN_MAX:59.99 wraps to 00:00.00
module stopwatch_core
    import watch_pkg::*;
#(
    parameter int unsigned MIN_MAX = 59
) (
    input  logic                          CLOCK,
    input  logic                          RESET_n,
    input  logic                          _100Hz_clk,
    input  logic                          start_stop,
    input  logic                          lap,
    input  logic                          clear,
    output logic [NUM_DIGITS*DIGIT_W-1:0] disp_bcd,
    output logic                          running,
    output logic                          overflow
);

    localparam logic [2*DIGIT_W-1:0] MIN_MAX_BCD = to_bcd2(MIN_MAX);

    state_t state, state_next;

    logic hz_prev;
    logic tick;
    logic adv;
    logic zero;
    logic wrap;
    logic at_max;
    logic lap_enter;
    logic dig_clr;

    logic [NUM_DIGITS-1:0]              dig_en;
    logic [NUM_DIGITS-1:0]              carry;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0] dig_q;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0] dig_next;
    logic [NUM_DIGITS*DIGIT_W-1:0]      lap_q;

    assign tick = !hz_prev && _100Hz_clk;
    // Count decision uses the state before this cycle's transition.
    assign adv  = tick && ((state == RUN) || (state == LAP));

    always_comb begin
        state_next = state;
        zero       = 1'b0;
        if (clear) begin
            state_next = IDLE;
            zero       = 1'b1;
        end else if (start_stop) begin
            case (state)
                IDLE:    state_next = RUN;
                RUN:     state_next = PAUSE;
                LAP:     state_next = PAUSE;
                PAUSE:   state_next = RUN;
                default: state_next = IDLE;
            endcase
        end else if (lap) begin
            case (state)
                RUN:   state_next = LAP;
                LAP:   state_next = RUN;
                PAUSE: begin
                    state_next = IDLE;
                    zero       = 1'b1;
                end
                default: state_next = state;
            endcase
        end
    end

    // Digit chain: cs_u is index 0, min_t index 5; sec_t counts modulo 6.
    assign dig_en = {carry[NUM_DIGITS-2:0], adv};

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        bcd_digit #(
            .MODULUS((i == 3) ? 6 : 10)
        ) u_digit (
            .clk    (CLOCK),
            .rst_n  (RESET_n),
            .en     (dig_en[i]),
            .clr    (dig_clr),
            .q      (dig_q[i]),
            .q_next (dig_next[i]),
            .carry  (carry[i])
        );
    end

    // Seconds roll over while minutes sit at MIN_MAX; the min_t carry also
    // catches the hundred-minute rollover so minutes can never pass 99.
    assign at_max    = carry[3] && ({dig_q[5], dig_q[4]} == MIN_MAX_BCD);
    assign wrap      = (at_max || carry[NUM_DIGITS-1]) && !zero;
    assign dig_clr   = zero || wrap;
    assign lap_enter = (state_next == LAP) && (state != LAP);

    always_ff @(negedge CLOCK or negedge RESET_n) begin
        if (!RESET_n) begin
            state    <= IDLE;
            hz_prev  <= 1'b0;
            lap_q    <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_next;
            hz_prev  <= _100Hz_clk;
            overflow <= wrap;
            if (zero) begin
                lap_q <= '0;
            end else if (lap_enter) begin
                lap_q <= dig_next;
            end
        end
    end

    assign running  = (state == RUN) || (state == LAP);
    assign disp_bcd = (state == LAP) ? lap_q : dig_q;

endmodule

// File: tb/tb_stopwatch_core.sv
module tb_stopwatch_core;

    logic CLOCK = 1'b0;
    logic RESET_n;

    int n_checks = 0;
    int n_fail   = 0;

    always #10 CLOCK = ~CLOCK;

    stopwatch_core_if sw_if ();

    stopwatch_core #(
        .MIN_MAX(1)
    ) dut (
        .CLOCK      (CLOCK),
        .RESET_n    (RESET_n),
        ._100Hz_clk (sw_if._100Hz_clk),
        .start_stop (sw_if.start_stop),
        .lap        (sw_if.lap),
        .clear      (sw_if.clear),
        .disp_bcd   (sw_if.disp_bcd),
        .running    (sw_if.running),
        .overflow   (sw_if.overflow)
    );

    // n rising edges on the 100 Hz input; returns just after the posedge
    // that follows the last sampled edge, so the new count is visible.
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLOCK);
            sw_if._100Hz_clk = 1'b0;
            @(posedge CLOCK);
            sw_if._100Hz_clk = 1'b1;
        end
        @(posedge CLOCK);
        #1;
    endtask

    task automatic press(input logic ss, input logic lp, input logic clr);
        @(posedge CLOCK);
        sw_if.start_stop = ss;
        sw_if.lap        = lp;
        sw_if.clear      = clr;
        @(posedge CLOCK);
        sw_if.start_stop = 1'b0;
        sw_if.lap        = 1'b0;
        sw_if.clear      = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        RESET_n = 1'b0;
        #25;
        n_checks++;
        if (sw_if.disp_bcd !== 24'h000000) begin
            n_fail++; $display("FAIL reset_disp: got %h expected 000000", sw_if.disp_bcd);
        end
        n_checks++;
        if (sw_if.running !== 1'b0) begin
            n_fail++; $display("FAIL reset_running: got %b expected 0", sw_if.running);
        end
        n_checks++;
        if (sw_if.overflow !== 1'b0) begin
            n_fail++; $display("FAIL reset_overflow: got %b expected 0", sw_if.overflow);
        end
        @(posedge CLOCK);
        RESET_n = 1'b1;
        #1;
    endtask

    task automatic test_idle_ticks();
        ticks(10);
        n_checks++;
        if (sw_if.disp_bcd !== 24'h000000) begin
            n_fail++; $display("FAIL idle_ticks: got %h expected 000000", sw_if.disp_bcd);
        end
    endtask

    task automatic test_count_100();
        press(1'b1, 1'b0, 1'b0);
        ticks(100);
        n_checks++;
        if (sw_if.disp_bcd !== 24'h000100) begin
            n_fail++; $display("FAIL count_100: got %h expected 000100", sw_if.disp_bcd);
        end
        n_checks++;
        if (sw_if.running !== 1'b1) begin
            n_fail++; $display("FAIL count_100_running: got %b expected 1", sw_if.running);
        end
    endtask

    task automatic test_minute_carry();
        ticks(5899);
        n_checks++;
        if (sw_if.disp_bcd !== 24'h005999) begin
            n_fail++; $display("FAIL pre_minute: got %h expected 005999", sw_if.disp_bcd);
        end
        ticks(1);
        n_checks++;
        if (sw_if.disp_bcd !== 24'h010000) begin
            n_fail++; $display("FAIL minute_carry: got %h expected 010000", sw_if.disp_bcd);
        end
        n_checks++;
        if (sw_if.overflow !== 1'b0) begin
            n_fail++; $display("FAIL minute_carry_ovf: got %b expected 0", sw_if.overflow);
        end
    endtask

    task automatic test_wrap();
        ticks(5999);
        n_checks++;
        if (sw_if.disp_bcd !== 24'h015999) begin
            n_fail++; $display("FAIL pre_wrap: got %h expected 015999", sw_if.disp_bcd);
        end
        ticks(1);
        n_checks++;
        if (sw_if.disp_bcd !== 24'h000000) begin
            n_fail++; $display("FAIL wrap_disp: got %h expected 000000", sw_if.disp_bcd);
        end
        n_checks++;
        if (sw_if.overflow !== 1'b1) begin
            n_fail++; $display("FAIL wrap_ovf_high: got %b expected 1", sw_if.overflow);
        end
        n_checks++;
        if (sw_if.running !== 1'b1) begin
            n_fail++; $display("FAIL wrap_running: got %b expected 1", sw_if.running);
        end
        @(posedge CLOCK);
        #1;
        n_checks++;
        if (sw_if.overflow !== 1'b0) begin
            n_fail++; $display("FAIL wrap_ovf_low: got %b expected 0", sw_if.overflow);
        end
        ticks(1);
        n_checks++;
        if (sw_if.disp_bcd !== 24'h000001) begin
            n_fail++; $display("FAIL after_wrap: got %h expected 000001", sw_if.disp_bcd);
        end
    endtask

    task automatic test_pause();
        press(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (sw_if.running !== 1'b0) begin
            n_fail++; $display("FAIL pause_running: got %b expected 0", sw_if.running);
        end
        ticks(20);
        n_checks++;
        if (sw_if.disp_bcd !== 24'h000001) begin
            n_fail++; $display("FAIL pause_hold: got %h expected 000001", sw_if.disp_bcd);
        end
        press(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (sw_if.disp_bcd !== 24'h000000) begin
            n_fail++; $display("FAIL pause_lap_zero: got %h expected 000000", sw_if.disp_bcd);
        end
    endtask

    task automatic test_lap();
        press(1'b1, 1'b0, 1'b0);
        ticks(1234);
        press(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (sw_if.disp_bcd !== 24'h001234) begin
            n_fail++; $display("FAIL lap_capture: got %h expected 001234", sw_if.disp_bcd);
        end
        ticks(50);
        n_checks++;
        if (sw_if.disp_bcd !== 24'h001234) begin
            n_fail++; $display("FAIL lap_hold: got %h expected 001234", sw_if.disp_bcd);
        end
        n_checks++;
        if (sw_if.running !== 1'b1) begin
            n_fail++; $display("FAIL lap_running: got %b expected 1", sw_if.running);
        end
        press(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (sw_if.disp_bcd !== 24'h001284) begin
            n_fail++; $display("FAIL lap_release: got %h expected 001284", sw_if.disp_bcd);
        end
        // lap entry on the same cycle as a tick captures the incremented count
        @(posedge CLOCK);
        sw_if._100Hz_clk = 1'b0;
        @(posedge CLOCK);
        sw_if._100Hz_clk = 1'b1;
        sw_if.lap        = 1'b1;
        @(posedge CLOCK);
        sw_if.lap = 1'b0;
        #1;
        n_checks++;
        if (sw_if.disp_bcd !== 24'h001285) begin
            n_fail++; $display("FAIL lap_with_tick: got %h expected 001285", sw_if.disp_bcd);
        end
        ticks(10);
        press(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (sw_if.disp_bcd !== 24'h001295) begin
            n_fail++; $display("FAIL lap_to_pause: got %h expected 001295", sw_if.disp_bcd);
        end
        n_checks++;
        if (sw_if.running !== 1'b0) begin
            n_fail++; $display("FAIL lap_to_pause_running: got %b expected 0", sw_if.running);
        end
    endtask

    task automatic test_clear_start();
        press(1'b0, 1'b0, 1'b1);
        press(1'b1, 1'b0, 1'b0);
        ticks(500);
        n_checks++;
        if (sw_if.disp_bcd !== 24'h000500) begin
            n_fail++; $display("FAIL pre_clear: got %h expected 000500", sw_if.disp_bcd);
        end
        press(1'b1, 1'b0, 1'b1);
        n_checks++;
        if (sw_if.disp_bcd !== 24'h000000) begin
            n_fail++; $display("FAIL clear_start_disp: got %h expected 000000", sw_if.disp_bcd);
        end
        n_checks++;
        if (sw_if.running !== 1'b0) begin
            n_fail++; $display("FAIL clear_start_running: got %b expected 0", sw_if.running);
        end
    endtask

    task automatic test_key_priority();
        press(1'b1, 1'b0, 1'b0);
        ticks(3);
        press(1'b1, 1'b1, 1'b0);
        n_checks++;
        if (sw_if.running !== 1'b0) begin
            n_fail++; $display("FAIL ss_over_lap_running: got %b expected 0", sw_if.running);
        end
        ticks(5);
        n_checks++;
        if (sw_if.disp_bcd !== 24'h000003) begin
            n_fail++; $display("FAIL ss_over_lap_hold: got %h expected 000003", sw_if.disp_bcd);
        end
    endtask

    task automatic test_clear_tick();
        press(1'b1, 1'b0, 1'b0);
        ticks(4);
        n_checks++;
        if (sw_if.disp_bcd !== 24'h000007) begin
            n_fail++; $display("FAIL resume_count: got %h expected 000007", sw_if.disp_bcd);
        end
        @(posedge CLOCK);
        sw_if._100Hz_clk = 1'b0;
        @(posedge CLOCK);
        sw_if._100Hz_clk = 1'b1;
        sw_if.clear      = 1'b1;
        @(posedge CLOCK);
        sw_if.clear = 1'b0;
        #1;
        n_checks++;
        if (sw_if.disp_bcd !== 24'h000000) begin
            n_fail++; $display("FAIL clear_tick_disp: got %h expected 000000", sw_if.disp_bcd);
        end
        n_checks++;
        if (sw_if.overflow !== 1'b0) begin
            n_fail++; $display("FAIL clear_tick_ovf: got %b expected 0", sw_if.overflow);
        end
        n_checks++;
        if (sw_if.running !== 1'b0) begin
            n_fail++; $display("FAIL clear_tick_running: got %b expected 0", sw_if.running);
        end
    endtask

    task automatic test_reset_mid();
        press(1'b1, 1'b0, 1'b0);
        ticks(8107);
        n_checks++;
        if (sw_if.disp_bcd !== 24'h012107) begin
            n_fail++; $display("FAIL pre_reset: got %h expected 012107", sw_if.disp_bcd);
        end
        @(posedge CLOCK);
        #3;
        RESET_n = 1'b0;
        #1;
        n_checks++;
        if (sw_if.disp_bcd !== 24'h000000) begin
            n_fail++; $display("FAIL async_reset_disp: got %h expected 000000", sw_if.disp_bcd);
        end
        n_checks++;
        if (sw_if.running !== 1'b0) begin
            n_fail++; $display("FAIL async_reset_running: got %b expected 0", sw_if.running);
        end
        n_checks++;
        if (sw_if.overflow !== 1'b0) begin
            n_fail++; $display("FAIL async_reset_ovf: got %b expected 0", sw_if.overflow);
        end
        // 100 Hz input stays high across release: no edge, so no count
        @(posedge CLOCK);
        RESET_n = 1'b1;
        repeat (3) @(posedge CLOCK);
        press(1'b1, 1'b0, 1'b0);
        repeat (4) @(posedge CLOCK);
        #1;
        n_checks++;
        if (sw_if.disp_bcd !== 24'h000000) begin
            n_fail++; $display("FAIL post_reset_no_edge: got %h expected 000000", sw_if.disp_bcd);
        end
        n_checks++;
        if (sw_if.running !== 1'b1) begin
            n_fail++; $display("FAIL post_reset_running: got %b expected 1", sw_if.running);
        end
        ticks(1);
        n_checks++;
        if (sw_if.disp_bcd !== 24'h000001) begin
            n_fail++; $display("FAIL post_reset_edge: got %h expected 000001", sw_if.disp_bcd);
        end
    endtask

    initial begin
        sw_if._100Hz_clk = 1'b0;
        sw_if.start_stop = 1'b0;
        sw_if.lap        = 1'b0;
        sw_if.clear      = 1'b0;
        test_reset();
        test_idle_ticks();
        test_count_100();
        test_minute_carry();
        test_wrap();
        test_pause();
        test_lap();
        test_clear_start();
        test_key_priority();
        test_clear_tick();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
